// File: rtl/wb_mcu_dpram.sv
// Dual-port shared memory: Wishbone slave on one side, async MCU SRAM bus
// on the other, with MCU write commit FSM, collision priority and doorbell.
module wb_mcu_dpram #(
  parameter int MCU_ADR_WIDTH  = 11,
  parameter int MCU_DATA_WIDTH = 8,
  parameter int WB_DATA_WIDTH  = 16,
  parameter int WB_ADR_WIDTH   =
    MCU_ADR_WIDTH - $clog2(WB_DATA_WIDTH / MCU_DATA_WIDTH),
  parameter int SYNC_STAGES    = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      wb_cyc_i,
  input  logic                                      wb_stb_i,
  input  logic                                      wb_we_i,
  input  logic [WB_ADR_WIDTH-1:0]                   wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]                  wb_dat_i,
  input  logic [WB_DATA_WIDTH/MCU_DATA_WIDTH-1:0]   wb_sel_i,
  output logic [WB_DATA_WIDTH-1:0]                  wb_dat_o,
  output logic                                      wb_ack_o,
  input  logic                                      mcu_ncs,
  input  logic                                      mcu_nwe,
  input  logic                                      mcu_nrd,
  input  logic [MCU_ADR_WIDTH-1:0]                  mcu_addr,
  inout  wire  [MCU_DATA_WIDTH-1:0]                 mcu_sram_data,
  output logic                                      irq_o
);

  localparam int R  = WB_DATA_WIDTH / MCU_DATA_WIDTH;
  localparam int LR = $clog2(R);
  localparam int AW = MCU_ADR_WIDTH;
  localparam int DW = MCU_DATA_WIDTH;
  localparam int S  = SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

  logic [S-1:0]  ncs_sr;
  logic [S-1:0]  nwe_sr;
  logic [AW-1:0] addr_sr [S];
  logic [DW-1:0] data_sr [S];
  logic [AW-1:0] addr_s;
  logic [DW-1:0] data_s;
  logic          wact;

  state_t        state;
  state_t        nxt;
  logic          latch_en;
  logic          commit;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] data_l;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;

  logic          access;
  logic          wb_wr;
  logic [AW-1:0] base;
  logic [AW-1:0] lane_addr [R];
  logic [WB_DATA_WIDTH-1:0] rd_word;

  logic          db_set;
  logic          db_clr;

  // Bring MCU strobes, address and data into the clk_i domain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ncs_sr <= '1;
      nwe_sr <= '1;
      for (int i = 0; i < S; i++) begin
        addr_sr[i] <= '0;
        data_sr[i] <= '0;
      end
    end else begin
      ncs_sr     <= {ncs_sr[S-2:0], mcu_ncs};
      nwe_sr     <= {nwe_sr[S-2:0], mcu_nwe};
      addr_sr[0] <= mcu_addr;
      data_sr[0] <= mcu_sram_data;
      for (int i = 1; i < S; i++) begin
        addr_sr[i] <= addr_sr[i-1];
        data_sr[i] <= data_sr[i-1];
      end
    end
  end

  assign addr_s = addr_sr[S-1];
  assign data_s = data_sr[S-1];
  assign wact   = ~ncs_sr[S-1] & ~nwe_sr[S-1];

  // Write FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nxt;
  end

  // Write FSM next state: commit once the MCU write strobe drops
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (wact)  nxt = ACTIVE;
      ACTIVE:  if (!wact) nxt = COMMIT;
      COMMIT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Write FSM outputs
  always_comb begin
    latch_en = (state == ACTIVE);
    commit   = (state == COMMIT);
  end

  // Track the MCU address/data while the write strobe is active
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_l <= '0;
      data_l <= '0;
    end else if (latch_en) begin
      addr_l <= addr_s;
      data_l <= data_s;
    end
  end

  assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wb_wr  = access & wb_we_i;
  assign base   = AW'(wb_adr_i) << LR;

  // MCU-word address of each Wishbone lane and the assembled read word
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < R; k++) begin
      lane_addr[k] = base | AW'(k);
      rd_word[k*DW +: DW] = mem[base | AW'(k)];
    end
  end

  // Memory: WB lanes colliding with an MCU commit are dropped; not reset
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < R; k++) begin
      if (wb_wr && wb_sel_i[k] &&
          !(commit && addr_l == lane_addr[k]))
        mem[lane_addr[k]] <= wb_dat_i[k*DW +: DW];
    end
    if (commit) mem[addr_l] <= data_l;
  end

  // Wishbone registered acknowledge and read data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= access;
      if (access && !wb_we_i) wb_dat_o <= rd_word;
    end
  end

  // MCU read register follows the synchronised address every cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_q <= '0;
    else       rd_q <= mem[addr_s];
  end

  assign mcu_sram_data = (!mcu_nrd && !mcu_ncs) ? rd_q : 'z;

  assign db_set = commit && (addr_l == '1);
  assign db_clr = wb_wr && (wb_adr_i == '1) && wb_sel_i[R-1];

  // Doorbell: MCU commit to the last address sets, host write clears
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       irq_o <= 1'b0;
    else if (db_set) irq_o <= 1'b1;
    else if (db_clr) irq_o <= 1'b0;
  end

endmodule

// File: tb/tb_wb_mcu_dpram.sv
// Bench for wb_mcu_dpram: two instances (16-bit/2-stage, 32-bit/3-stage),
// table-driven Wishbone vectors with a read scoreboard plus MCU sequences.
module tb_wb_mcu_dpram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cur = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [9:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        ncs = 1'b1;
  logic        nwe = 1'b1;
  logic        nrd = 1'b1;
  logic        men = 1'b0;
  logic [10:0] maddr = '0;
  logic [7:0]  mdrv = '0;
  wire  [7:0]  d0;
  wire  [7:0]  d1;
  logic [15:0] dat0;
  logic [31:0] dat1;
  logic        ack0, ack1, irq0, irq1;
  logic        ack, irq;
  logic [31:0] rdat;
  logic [7:0]  rbus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign d0 = (men && !cur) ? mdrv : 'z;
  assign d1 = (men && cur) ? mdrv : 'z;

  assign ack  = cur ? ack1 : ack0;
  assign irq  = cur ? irq1 : irq0;
  assign rdat = cur ? dat1 : {16'h0, dat0};
  assign rbus = cur ? d1 : d0;

  wb_mcu_dpram u0 (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc & ~cur), .wb_stb_i(stb & ~cur), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat[15:0]), .wb_sel_i(sel[1:0]),
    .wb_dat_o(dat0), .wb_ack_o(ack0),
    .mcu_ncs(ncs | cur), .mcu_nwe(nwe), .mcu_nrd(nrd),
    .mcu_addr(maddr), .mcu_sram_data(d0), .irq_o(irq0)
  );

  wb_mcu_dpram #(.WB_DATA_WIDTH(32), .SYNC_STAGES(3)) u1 (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc & cur), .wb_stb_i(stb & cur), .wb_we_i(we),
    .wb_adr_i(adr[8:0]), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(dat1), .wb_ack_o(ack1),
    .mcu_ncs(ncs | ~cur), .mcu_nwe(nwe), .mcu_nrd(nrd),
    .mcu_addr(maddr), .mcu_sram_data(d1), .irq_o(irq1)
  );

  typedef struct {
    bit          u;
    bit          w;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] e;
    string       n;
  } vec_t;

  typedef struct {
    bit          w;
    logic [31:0] e;
    string       n;
  } exp_t;

  vec_t tv [17];
  exp_t sb [$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Scoreboard: every ack pops one expectation; reads compare data
  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack actual=1 required=0");
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (!x.w) chk(x.n, rdat, x.e);
      end
    end
  end

  function automatic vec_t mk(bit u, bit w, logic [9:0] a, logic [31:0] d,
                              logic [3:0] s, logic [31:0] e, string n);
    vec_t v;
    v.u = u; v.w = w; v.a = a; v.d = d; v.s = s; v.e = e; v.n = n;
    return v;
  endfunction

  // Called at a negedge; returns two negedges later (ack then idle)
  task automatic wb_issue(input bit w, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] e, input string n);
    exp_t x;
    x.w = w; x.e = e; x.n = n;
    sb.push_back(x);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk);
    #1 chk({n, "_ack"}, {31'h0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({n, "_ackpulse"}, {31'h0, ack}, 32'h0);
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cur = tv[i].u;
      wb_issue(tv[i].w, tv[i].a, tv[i].d, tv[i].s, tv[i].e, tv[i].n);
    end
  endtask

  // Returns at the negedge on which the MCU write strobe rose
  task automatic mcu_wr_begin(input logic [10:0] a, input logic [7:0] d);
    maddr = a; mdrv = d; men = 1'b1; ncs = 1'b0;
    repeat (2) @(negedge clk);
    nwe = 1'b0;
    repeat (5) @(negedge clk);
    nwe = 1'b1;
  endtask

  task automatic mcu_wr_end;
    repeat (6) @(negedge clk);
    ncs = 1'b1; men = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic mcu_rd(input logic [10:0] a, input logic [7:0] e,
                        input string n);
    int ss;
    ss = cur ? 3 : 2;
    maddr = a; men = 1'b0; ncs = 1'b0; nrd = 1'b0;
    repeat (ss + 1) @(posedge clk);
    #1 chk(n, {24'h0, rbus}, {24'h0, e});
    @(negedge clk);
    nrd = 1'b1; ncs = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = mk(0, 1, 10'h010, 32'hA55A, 4'h3, 32'h0, "w_a55a");
    tv[1]  = mk(0, 0, 10'h010, 32'h0, 4'h0, 32'hA55A, "r_a55a");
    tv[2]  = mk(0, 1, 10'h003, 32'h0000, 4'h3, 32'h0, "w_clr3");
    tv[3]  = mk(0, 1, 10'h005, 32'hBEEF, 4'h3, 32'h0, "w_beef");
    tv[4]  = mk(0, 1, 10'h005, 32'h1200, 4'h2, 32'h0, "w_hi");
    tv[5]  = mk(0, 0, 10'h005, 32'h0, 4'h0, 32'h12EF, "r_sel_hi");
    tv[6]  = mk(0, 1, 10'h005, 32'hFF34, 4'h1, 32'h0, "w_lo");
    tv[7]  = mk(0, 0, 10'h005, 32'h0, 4'h0, 32'h1234, "r_sel_lo");
    tv[8]  = mk(0, 1, 10'h005, 32'hFFFF, 4'h0, 32'h0, "w_none");
    tv[9]  = mk(0, 0, 10'h005, 32'h0, 4'h0, 32'h1234, "r_sel_none");
    tv[10] = mk(0, 1, 10'h008, 32'h5555, 4'h3, 32'h0, "w_5555");
    tv[11] = mk(0, 1, 10'h3FF, 32'h0000, 4'h3, 32'h0, "w_last");
    tv[12] = mk(0, 0, 10'h3FF, 32'h0, 4'h0, 32'h0000, "r_last");
    tv[13] = mk(1, 1, 10'h010, 32'h0, 4'hF, 32'h0, "u1_w_clr");
    tv[14] = mk(1, 1, 10'h010, 32'hFFFFA55A, 4'h3, 32'h0, "u1_w_a55a");
    tv[15] = mk(1, 0, 10'h010, 32'h0, 4'h0, 32'h0000A55A, "u1_r_a55a");
    tv[16] = mk(1, 1, 10'h001, 32'h0, 4'hF, 32'h0, "u1_w_clr1");

    repeat (3) @(negedge clk);
    chk("rst_ack0", {31'h0, ack0}, 32'h0);
    chk("rst_dat0", {16'h0, dat0}, 32'h0);
    chk("rst_irq0", {31'h0, irq0}, 32'h0);
    chk("rst_ack1", {31'h0, ack1}, 32'h0);
    chk("rst_dat1", dat1, 32'h0);
    chk("rst_irq1", {31'h0, irq1}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    apply(0, 12);
    mcu_rd(11'h020, 8'h5A, "mrd_20");
    mcu_rd(11'h021, 8'hA5, "mrd_21");
    mcu_rd(11'h00A, 8'h34, "mrd_0a");
    mcu_rd(11'h00B, 8'h12, "mrd_0b");

    mcu_wr_begin(11'h007, 8'h3C);
    repeat (3) @(negedge clk);
    wb_issue(0, 10'h003, 32'h0, 4'h0, 32'h0000, "mwr_early");
    wb_issue(0, 10'h003, 32'h0, 4'h0, 32'h3C00, "mwr_new");
    mcu_wr_end();
    wb_issue(1, 10'h003, 32'h00FF, 4'h1, 32'h0, "w_ff");
    wb_issue(0, 10'h003, 32'h0, 4'h0, 32'h3CFF, "r_3cff");

    mcu_wr_begin(11'h040, 8'h11);
    repeat (3) @(negedge clk);
    wb_issue(1, 10'h020, 32'h2222, 4'h3, 32'h0, "w_coll");
    mcu_wr_end();
    wb_issue(0, 10'h020, 32'h0, 4'h0, 32'h2211, "collision");

    mcu_wr_begin(11'h7FF, 8'h01);
    repeat (3) @(negedge clk);
    chk("irq_early", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_set", {31'h0, irq}, 32'h1);
    mcu_wr_end();
    wb_issue(0, 10'h3FF, 32'h0, 4'h0, 32'h0100, "db_data");
    wb_issue(1, 10'h3FF, 32'h0000, 4'h1, 32'h0, "w_db_lo");
    chk("irq_keep", {31'h0, irq}, 32'h1);
    wb_issue(1, 10'h3FF, 32'h0000, 4'h2, 32'h0, "w_db_hi");
    chk("irq_clr", {31'h0, irq}, 32'h0);

    mcu_wr_begin(11'h7FF, 8'h5A);
    repeat (3) @(negedge clk);
    wb_issue(1, 10'h3FF, 32'hA5A5, 4'h2, 32'h0, "w_db_coll");
    chk("irq_set_wins", {31'h0, irq}, 32'h1);
    mcu_wr_end();
    wb_issue(0, 10'h3FF, 32'h0, 4'h0, 32'h5A00, "db_coll_data");

    maddr = 11'h010; mdrv = 8'hEE; men = 1'b1; ncs = 1'b0;
    repeat (2) @(negedge clk);
    nwe = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_irq", {31'h0, irq}, 32'h0);
    chk("mrst_ack", {31'h0, ack}, 32'h0);
    nwe = 1'b1; ncs = 1'b1; men = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mrst_irq_after", {31'h0, irq}, 32'h0);
    wb_issue(0, 10'h008, 32'h0, 4'h0, 32'h5555, "mrst_nowrite");
    wb_issue(0, 10'h010, 32'h0, 4'h0, 32'hA55A, "mrst_keep");

    apply(13, 16);
    mcu_rd(11'h040, 8'h5A, "u1_mrd_40");
    mcu_rd(11'h041, 8'hA5, "u1_mrd_41");
    mcu_wr_begin(11'h007, 8'h3C);
    repeat (4) @(negedge clk);
    wb_issue(0, 10'h001, 32'h0, 4'h0, 32'h00000000, "u1_mwr_early");
    wb_issue(0, 10'h001, 32'h0, 4'h0, 32'h3C000000, "u1_mwr_new");
    mcu_wr_end();
    wb_issue(1, 10'h001, 32'h000000FF, 4'h1, 32'h0, "u1_w_ff");
    wb_issue(0, 10'h001, 32'h0, 4'h0, 32'h3C0000FF, "u1_r_3cff");

    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_mcu_dpram.md
# wb_mcu_dpram

Parametrised dual-port shared memory between the Wishbone bus and the MCU asynchronous SRAM-style bus, fully synchronous to the Wishbone clock. MCU strobes, address and data are synchronised into `clk_i`, and completed MCU writes are committed through a write state machine. The block adds a registered Wishbone acknowledge, configurable MCU/Wishbone width ratio, defined write-collision priority and an MCU-to-host doorbell interrupt. It sits on the Wishbone interconnect as the MCU mailbox/shared-buffer peripheral.

## Interface
- `MCU_ADR_WIDTH`, 11, MCU byte-address width; memory holds 2^MCU_ADR_WIDTH MCU words.
- `MCU_DATA_WIDTH`, 8, MCU data width.
- `WB_DATA_WIDTH`, 16, Wishbone data width; R = WB_DATA_WIDTH/MCU_DATA_WIDTH, power of two, 1..8.
- `WB_ADR_WIDTH`, MCU_ADR_WIDTH-log2(R), Wishbone word-address width.
- `SYNC_STAGES`, 2, synchroniser depth for MCU inputs, 2..4.
- `clk_i` input 1 system clock; all logic on rising edge.
- `rst_i` input 1 asynchronous, active-high reset.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` input 1 Wishbone cycle, strobe, write enable.
- `wb_adr_i` input WB_ADR_WIDTH word address.
- `wb_dat_i` input WB_DATA_WIDTH write data.
- `wb_sel_i` input R byte-lane (MCU-word lane) selects.
- `wb_dat_o` output WB_DATA_WIDTH read data.
- `wb_ack_o` output 1 acknowledge.
- `mcu_ncs`, `mcu_nwe`, `mcu_nrd` input 1 MCU chip select, write, read strobes, active-low, asynchronous to `clk_i`.
- `mcu_addr` input MCU_ADR_WIDTH MCU address.
- `mcu_sram_data` inout MCU_DATA_WIDTH MCU data bus.
- `irq_o` output 1 doorbell interrupt to host, active-high level.

## Operation
- Address map: MCU address a = WB word a>>log2(R), lane a[log2(R)-1:0]; lane k occupies `wb_dat` bits [k*MCU_DATA_WIDTH +: MCU_DATA_WIDTH].
- Synchroniser: `mcu_ncs`, `mcu_nwe`, `mcu_addr`, `mcu_sram_data` each pass SYNC_STAGES flops; reset state ncs/nwe = 1, addr/data = 0. `wact` = synchronised ~ncs & ~nwe.
- MCU write FSM: IDLE -> ACTIVE when `wact`; in ACTIVE latch synchronised addr/data every cycle; ACTIVE -> COMMIT when `wact` falls; COMMIT writes last latched addr/data to memory for exactly one cycle -> IDLE. A new `wact` during COMMIT is ignored until IDLE (MCU cycle spacing guarantees ≥2 clocks).
- Reset mid-operation: FSM to IDLE, no write performed; memory contents not cleared.
- MCU read: read register loads memory[synchronised addr] every cycle; `mcu_sram_data` driven with it when raw `mcu_nrd`=0 and `mcu_ncs`=0, else high-Z.
- Wishbone: access = cyc & stb & ~ack. Write updates selected lanes only; read returns whole word. One ack per access.
- Collision: MCU COMMIT and WB write to the same word and lane in the same cycle -> MCU data stored, WB lane discarded, WB still acked. Other lanes of that WB write are stored.
- Doorbell: MCU COMMIT to address 2^MCU_ADR_WIDTH-1 stores the data and sets `irq_o`. WB write to the last WB word with sel[R-1]=1 clears `irq_o`. Set and clear in the same cycle -> set wins.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `irq_o`=0, MCU read register 0, FSM IDLE, `mcu_sram_data` high-Z unless read strobe active.
- WB: ack one cycle after access is presented, single-cycle pulse; `wb_dat_o` valid in the ack cycle and held until next access. Back-to-back accesses every 2 cycles.
- MCU write: memory updated SYNC_STAGES+2 clocks after `mcu_nwe` rises; WB read issued after that returns new data.
- MCU read: data valid on pins SYNC_STAGES+1 clocks after stable address; MCU read strobe must exceed SYNC_STAGES+2 clocks.
- `irq_o` rises the cycle after COMMIT to doorbell address; falls the cycle after the clearing WB write.

## Test plan
- WB write 0xA55A, sel=11, adr 0x10 -> ack 1 cycle later; MCU reads addr 0x20 = 0x5A, 0x21 = 0xA5.
- MCU writes 0x3C to addr 0x007 -> WB read adr 0x03 returns 0x3C00 with ack; sel=01 write of 0x00FF to adr 0x03 then leaves 0x3CFF.
- Same-cycle MCU COMMIT to addr 0x040 (0x11) and WB write adr 0x20 data 0x2222 sel=11 -> word reads 0x2211.
- MCU writes 0x01 to addr 0x7FF -> `irq_o`=1; WB write adr 0x3FF sel=10 -> `irq_o`=0; sel=01 write leaves it 1.
- Assert `rst_i` while FSM in ACTIVE -> no memory write, `irq_o`=0, `wb_ack_o`=0, data bus high-Z.
- Repeat first two scenarios with WB_DATA_WIDTH=32, SYNC_STAGES=3 -> lane mapping and latencies scale as specified.
